// File: rtl/can_tx_defs.sv
// ============================================================================
// Package    : can_tx_defs
// Description: Shared definitions for the CAN transmit bit stuffer: FSM state
//              encodings, bus level names and the default stuffing run length.
//              Optional monitor build macro used by the stuffer: TX_BITMON_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package can_tx_defs;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEND  = 2'b01,
        ST_STUFF = 2'b10
    } state_t;

    // Bus levels
    localparam logic BIT_REC = 1'b1;
    localparam logic BIT_DOM = 1'b0;

    // Default number of equal consecutive bits before a stuff bit
    localparam int STUFF_LEN_DEF = 5;

endpackage

`default_nettype wire

// File: rtl/can_stuff_cnt.sv
// ============================================================================
// Module     : can_stuff_cnt
// Description: Tracks the run of equal consecutive transmitted bits (cnt) and
//              the level of the last transmitted bit (last). Flags when a stuff
//              bit is due.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_stuff_cnt
    import can_tx_defs::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load_stuff,
    input  logic i_load_bit,
    input  logic i_bit,
    input  logic i_stuff_en,
    input  logic i_clear,
    input  logic i_first,
    output logic o_pending,
    output logic o_last
);

    localparam logic [2:0] C_LEN = 3'(STUFF_LEN);

    logic [2:0] r_cnt;
    logic       r_last;

    // Run-length tracking; clear beats stuff insertion beats a new data bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 3'd0;
            r_last <= BIT_REC;
        end else if (i_clear) begin
            r_cnt  <= 3'd0;
            r_last <= BIT_REC;
        end else if (i_load_stuff) begin
            // The stuff bit is the complement and opens a new run of one
            r_cnt  <= 3'd1;
            r_last <= ~r_last;
        end else if (i_load_bit) begin
            r_last <= i_bit;
            if (!i_stuff_en) begin
                r_cnt <= 3'd0;
            end else if ((i_bit == r_last) && !i_first) begin
                r_cnt <= (r_cnt == C_LEN) ? C_LEN : r_cnt + 3'd1;
            end else begin
                r_cnt <= 3'd1;
            end
        end
    end

    assign o_pending = (r_cnt == C_LEN);
    assign o_last    = r_last;

endmodule

`default_nettype wire

// File: rtl/can_txbit_stuffer.sv
// ============================================================================
// Module     : can_txbit_stuffer
// Description: CAN transmit bit path. Accepts frame bits from the MAC through
//              a req/ack handshake, drives txbit for one bit time per tx_tick
//              and inserts complementary stuff bits after STUFF_LEN equal bits.
//              Define TX_BITMON_EN to add the sample-point bit monitor
//              (bit error and arbitration-lost detection).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_txbit_stuffer
    import can_tx_defs::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_tx_tick,
    input  logic i_force_rec,
    input  logic i_tx_req,
    input  logic i_tx_bit_in,
    input  logic i_stuff_en,
`ifdef TX_BITMON_EN
    input  logic i_smpl_tick,
    input  logic i_smpldbit,
    input  logic i_arb,
    output logic o_bit_err,
    output logic o_arb_lost,
`endif
    output logic o_tx_ack,
    output logic o_txbit,
    output logic o_stuff_active,
    output logic o_tx_busy
);

    state_t r_state;
    logic   r_txbit;
    logic   r_ack;

    logic   w_pending;
    logic   w_last;
    logic   w_req;
    logic   w_arb_lose;

`ifdef TX_BITMON_EN
    logic   r_arb_block;
    logic   r_bit_err;
    logic   r_arb_lost;
    logic   w_bit_err_det;

    // Losing arbitration: we send recessive but the bus reads dominant
    assign w_arb_lose    = i_smpl_tick && !i_tx_tick && (r_state == ST_SEND) &&
                           (r_txbit == BIT_REC) && (i_smpldbit == BIT_DOM) && i_arb;
    assign w_bit_err_det = i_smpl_tick && !i_tx_tick && (r_state != ST_IDLE) &&
                           !w_arb_lose && (r_txbit != i_smpldbit);
    // A request that was live when arbitration was lost is ignored until it drops
    assign w_req         = i_tx_req && !r_arb_block;
`else
    assign w_arb_lose    = 1'b0;
    assign w_req         = i_tx_req;
`endif

    // Per-tick decision, first match wins
    logic w_take_force;
    logic w_take_stuff;
    logic w_take_bit;
    logic w_take_idle;

    assign w_take_force = i_tx_tick && i_force_rec;
    assign w_take_stuff = i_tx_tick && !i_force_rec && w_pending;
    assign w_take_bit   = i_tx_tick && !i_force_rec && !w_pending && w_req;
    assign w_take_idle  = i_tx_tick && !i_force_rec && !w_pending && !w_req;

    can_stuff_cnt #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuff_cnt (
        .clock        (clock),
        .reset        (reset),
        .i_load_stuff (w_take_stuff),
        .i_load_bit   (w_take_bit),
        .i_bit        (i_tx_bit_in),
        .i_stuff_en   (i_stuff_en),
        .i_clear      (w_take_force || w_take_idle || w_arb_lose),
        .i_first      (r_state == ST_IDLE),
        .o_pending    (w_pending),
        .o_last       (w_last)
    );

    // Transmit FSM with registered txbit and single-cycle ack
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_txbit <= BIT_REC;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_take_stuff) begin
                r_txbit <= ~w_last;
                r_state <= ST_STUFF;
            end else if (w_take_bit) begin
                r_txbit <= i_tx_bit_in;
                r_ack   <= 1'b1;
                r_state <= ST_SEND;
            end else if (w_take_force || w_take_idle || w_arb_lose) begin
                r_txbit <= BIT_REC;
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef TX_BITMON_EN
    // Sample-point monitor: one-cycle error pulses and the re-request block
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_err   <= 1'b0;
            r_arb_lost  <= 1'b0;
            r_arb_block <= 1'b0;
        end else begin
            r_bit_err  <= w_bit_err_det;
            r_arb_lost <= w_arb_lose;
            if (w_arb_lose) begin
                r_arb_block <= 1'b1;
            end else if (!i_tx_req) begin
                r_arb_block <= 1'b0;
            end
        end
    end

    assign o_bit_err  = r_bit_err;
    assign o_arb_lost = r_arb_lost;
`endif

    assign o_tx_ack       = r_ack;
    assign o_txbit        = r_txbit;
    assign o_stuff_active = (r_state == ST_STUFF);
    assign o_tx_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_can_txbit_stuffer.sv
// ============================================================================
// Module     : tb_can_txbit_stuffer
// Description: Self-checking bench for can_txbit_stuffer. Expected bus streams
//              are produced by a frame-level stuffing model. Monitor checks are
//              compiled in when TX_BITMON_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_txbit_stuffer;

    localparam int STUFF_LEN = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx_tick = 1'b0;
    logic force_rec = 1'b0;
    logic tx_req = 1'b0;
    logic tx_bit_in = 1'b1;
    logic stuff_en = 1'b0;
    logic tx_ack, txbit, stuff_active, tx_busy;
`ifdef TX_BITMON_EN
    logic smpl_tick = 1'b0;
    logic smpldbit = 1'b1;
    logic arb = 1'b0;
    logic bit_err, arb_lost;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    can_txbit_stuffer #(.STUFF_LEN(STUFF_LEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_tx_tick      (tx_tick),
        .i_force_rec    (force_rec),
        .i_tx_req       (tx_req),
        .i_tx_bit_in    (tx_bit_in),
        .i_stuff_en     (stuff_en),
`ifdef TX_BITMON_EN
        .i_smpl_tick    (smpl_tick),
        .i_smpldbit     (smpldbit),
        .i_arb          (arb),
        .o_bit_err      (bit_err),
        .o_arb_lost     (arb_lost),
`endif
        .o_tx_ack       (tx_ack),
        .o_txbit        (txbit),
        .o_stuff_active (stuff_active),
        .o_tx_busy      (tx_busy)
    );

    // One expected bus bit time
    typedef struct packed {
        logic txbit;
        logic ack;
        logic stuff;
    } exp_t;

    exp_t q[$];
    logic fb[$];   // frame bits
    logic fs[$];   // per-bit stuff enable

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Frame-level model: expand the frame into the bus stream with stuff bits
    function automatic void build_expect();
        int   run;
        logic prev;
        bit   have_prev;
        exp_t e;
        run = 0; prev = 1'b1; have_prev = 0;
        q.delete();
        for (int i = 0; i < fb.size(); i++) begin
            e.txbit = fb[i]; e.ack = 1'b1; e.stuff = 1'b0;
            q.push_back(e);
            if (fs[i]) run = (have_prev && fb[i] == prev) ? run + 1 : 1;
            else       run = 0;
            prev = fb[i]; have_prev = 1;
            if (run == STUFF_LEN) begin
                e.txbit = ~prev; e.ack = 1'b0; e.stuff = 1'b1;
                q.push_back(e);
                prev = ~prev;
                run  = 1;
            end
        end
    endfunction

    // One bit time: pulse tx_tick, check the update, then check it holds
    task automatic tick_check(input string tag, input logic e_tx, input logic e_ack,
                              input logic e_stf, input logic e_busy);
        @(negedge clock); tx_tick = 1'b1;
        @(posedge clock); #1; tx_tick = 1'b0;
        chk({tag, "_txbit"}, txbit, e_tx);
        chk({tag, "_ack"}, tx_ack, e_ack);
        chk({tag, "_stuff"}, stuff_active, e_stf);
        chk({tag, "_busy"}, tx_busy, e_busy);
        @(posedge clock); #1;
        chk({tag, "_hold_txbit"}, txbit, e_tx);
        chk({tag, "_ack_low"}, tx_ack, 1'b0);
        @(posedge clock);
    endtask

    task automatic idle_ticks(input string tag, input int n);
        tx_req = 1'b0;
        for (int i = 0; i < n; i++) tick_check(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Act as the MAC: present frame bits, advance on each expected ack
    task automatic run_frame(input string tag);
        int idx;
        build_expect();
        idx = 0;
        for (int k = 0; k < q.size(); k++) begin
            if (idx < fb.size()) begin
                tx_req = 1'b1; tx_bit_in = fb[idx]; stuff_en = fs[idx];
            end else begin
                tx_req = 1'b0;
            end
            tick_check($sformatf("%s_%0d", tag, k), q[k].txbit, q[k].ack, q[k].stuff, 1'b1);
            if (q[k].ack) idx++;
        end
        tx_req = 1'b0;
    endtask

    task automatic load_frame(input logic [63:0] bits, input logic [63:0] sen, input int len);
        fb.delete(); fs.delete();
        for (int i = 0; i < len; i++) begin
            fb.push_back(bits[len-1-i]);
            fs.push_back(sen[len-1-i]);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_txbit", txbit, 1'b1);
        chk("rst_ack", tx_ack, 1'b0);
        chk("rst_stuff", stuff_active, 1'b0);
        chk("rst_busy", tx_busy, 1'b0);
        @(negedge clock); reset = 1'b1;
        idle_ticks("idle", 3);

        // Five dominant bits then a recessive one: stuff 1 after the fifth
        load_frame(64'b000001, 64'b111111, 6);
        run_frame("run0");
        idle_ticks("gap", 1);

        // SOF then five recessive bits: stuff 0 after the fifth 1
        load_frame(64'b0111110, 64'b1111111, 7);
        run_frame("run1");
        idle_ticks("gap", 1);

        // Alternating 20 bits: no stuffing
        load_frame(64'h55555 ^ 64'hFFFFF, 64'hFFFFF, 20);
        run_frame("alt");
        idle_ticks("gap", 1);

        // Pending stuff survives stuff_en dropping; no stuffing afterwards
        load_frame(64'b000000000000, 64'b111110000000, 12);
        run_frame("tail");
        idle_ticks("gap", 1);

        // force_rec on the fourth equal bit aborts; next frame starts fresh
        load_frame(64'b000, 64'b111, 3);
        run_frame("pre");
        tx_req = 1'b1; tx_bit_in = 1'b0; stuff_en = 1'b1; force_rec = 1'b1;
        tick_check("force", 1'b1, 1'b0, 1'b0, 1'b0);
        force_rec = 1'b0; tx_req = 1'b0;
        load_frame(64'b000000, 64'b111111, 6);
        run_frame("post");
        idle_ticks("gap", 1);

        // A request raised and dropped between ticks is never seen
        @(negedge clock); tx_req = 1'b1;
        @(negedge clock); tx_req = 1'b0;
        tick_check("blip", 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized frames with long runs and a stuffed prefix
        for (int f = 0; f < 10; f++) begin
            int   len, region;
            logic b;
            len    = $urandom_range(40, 8);
            region = $urandom_range(len, len / 2);
            fb.delete(); fs.delete();
            b = 1'b0;
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(2, 0) == 0) b = ~b;
                fb.push_back(b);
                fs.push_back(i < region);
            end
            run_frame($sformatf("rnd%0d", f));
            idle_ticks("rgap", $urandom_range(3, 1));
        end

        // Asynchronous reset mid-frame
        tx_req = 1'b1; tx_bit_in = 1'b0; stuff_en = 1'b1;
        tick_check("pre_rst", 1'b0, 1'b1, 1'b0, 1'b1);
        #2; reset = 1'b0; #1;
        chk("arst_txbit", txbit, 1'b1);
        chk("arst_busy", tx_busy, 1'b0);
        chk("arst_ack", tx_ack, 1'b0);
        tx_req = 1'b0;
        @(negedge clock); reset = 1'b1;
        idle_ticks("post_rst", 1);

`ifdef TX_BITMON_EN
        // Arbitration lost while sending recessive
        tx_req = 1'b1; tx_bit_in = 1'b1; stuff_en = 1'b1; arb = 1'b1;
        tick_check("arb_send", 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clock); smpl_tick = 1'b1; smpldbit = 1'b0;
        @(posedge clock); #1; smpl_tick = 1'b0; smpldbit = 1'b1;
        chk("arb_lost", arb_lost, 1'b1);
        chk("arb_no_berr", bit_err, 1'b0);
        chk("arb_txbit", txbit, 1'b1);
        chk("arb_busy", tx_busy, 1'b0);
        @(posedge clock); #1;
        chk("arb_pulse", arb_lost, 1'b0);
        tick_check("arb_block", 1'b1, 1'b0, 1'b0, 1'b0);
        tx_req = 1'b0; arb = 1'b0;
        idle_ticks("arb_gap", 1);

        // Same mismatch outside arbitration: bit error only
        tx_req = 1'b1; tx_bit_in = 1'b1;
        tick_check("berr_send", 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clock); smpl_tick = 1'b1; smpldbit = 1'b0;
        @(posedge clock); #1; smpl_tick = 1'b0; smpldbit = 1'b1;
        chk("berr", bit_err, 1'b1);
        chk("berr_no_arb", arb_lost, 1'b0);
        chk("berr_busy", tx_busy, 1'b1);
        chk("berr_txbit", txbit, 1'b1);
        tx_req = 1'b0;
        idle_ticks("berr_gap", 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
